// File: rtl/combine_user_scheduler.sv
// Round-robin combine scheduler: counts per-user ping-pong buffer writes and
// grants one pending, enabled user at a time to the combine engine.
module combine_user_scheduler #(
  parameter int NUM_USERS = 8,
  parameter int UIDX_W    = 4,
  parameter int PEND_W    = 2
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rstn,
  input  logic                 i_rdm_slot_start,
  input  logic                 i_slot_abort,
  input  logic [NUM_USERS-1:0] i_user_enable_mask,
  input  logic [NUM_USERS-1:0] io_Input_PingPong_Buffer_Write_Indicator,
  input  logic                 i_current_cb_combine_comp,
  output logic                 o_Combine_process_request,
  output logic [UIDX_W-1:0]    o_Combine_user_index,
  output logic [NUM_USERS-1:0] o_user_pending_ovf,
  output logic                 o_busy
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_SELECT   = 4'b0010,
    ST_PROGRESS = 4'b0100,
    ST_COMP     = 4'b1000
  } state_e;

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [NUM_USERS-1:0]  ind_q, ind_d;
  logic [PEND_W-1:0]     cnt_q [NUM_USERS];
  logic [PEND_W-1:0]     cnt_d [NUM_USERS];
  logic [NUM_USERS-1:0]  ovf_q, ovf_d;
  logic [UIDX_W-1:0]     ptr_q, ptr_d;
  logic [UIDX_W-1:0]     grant_q, grant_d;
  logic                  req_q, req_d;
  logic [UIDX_W-1:0]     uidx_q, uidx_d;
  logic                  busy_q, busy_d;

  logic [NUM_USERS-1:0]  wr_evt;
  logic [NUM_USERS-1:0]  elig;
  logic [NUM_USERS-1:0]  dec_vec;
  logic                  sel_found;
  logic [UIDX_W-1:0]     sel_idx;
  int                    best_off;
  int                    off;

  assign wr_evt = io_Input_PingPong_Buffer_Write_Indicator ^ ind_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    elig    = '0;
    dec_vec = '0;
    for (int u = 0; u < NUM_USERS; u++) begin
      elig[u]    = (cnt_q[u] != '0) && i_user_enable_mask[u];
      dec_vec[u] = (state_q == ST_COMP) && (grant_q == UIDX_W'(u));
    end
  end

  // Pick the eligible user closest to the pointer, counting forward with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_off  = NUM_USERS;
    off       = 0;
    for (int u = 0; u < NUM_USERS; u++) begin
      off = (u + NUM_USERS - int'(ptr_q)) % NUM_USERS;
      if (elig[u] && (off < best_off)) begin
        best_off  = off;
        sel_idx   = UIDX_W'(u);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ind_d   = io_Input_PingPong_Buffer_Write_Indicator;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE:     if (i_rdm_slot_start) state_d = ST_SELECT;
      ST_SELECT:   if (sel_found) begin
                     grant_d = sel_idx;
                     state_d = ST_PROGRESS;
                   end
      ST_PROGRESS: if (i_current_cb_combine_comp) state_d = ST_COMP;
      ST_COMP:     begin
                     ptr_d   = (grant_q == UIDX_W'(NUM_USERS - 1)) ? '0 : grant_q + 1'b1;
                     state_d = ST_SELECT;
                   end
      default:     state_d = ST_IDLE;
    endcase

    // A write landing on the decrementing user cancels out, so it never overflows.
    for (int u = 0; u < NUM_USERS; u++) begin
      if (wr_evt[u] && !dec_vec[u]) begin
        if (cnt_q[u] == CNT_MAX) ovf_d[u] = 1'b1;
        else                     cnt_d[u] = cnt_q[u] + 1'b1;
      end else if (dec_vec[u] && !wr_evt[u] && (cnt_q[u] != '0)) begin
        cnt_d[u] = cnt_q[u] - 1'b1;
      end
    end

    if (i_slot_abort) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      ovf_d   = '0;
      for (int u = 0; u < NUM_USERS; u++) cnt_d[u] = '0;
    end

    req_d  = (state_d == ST_PROGRESS);
    busy_d = (state_d != ST_IDLE);
    uidx_d = ((state_d == ST_PROGRESS) || (state_d == ST_COMP)) ? grant_d : '1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from the same edge.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q <= ST_IDLE;
      ind_q   <= '0;
      ovf_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      req_q   <= 1'b0;
      uidx_q  <= '1;
      busy_q  <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // safe and required to reset it element by element.
      for (int u = 0; u < NUM_USERS; u++) cnt_q[u] <= '0;
    end else begin
      state_q <= state_d;
      ind_q   <= ind_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      uidx_q  <= uidx_d;
      busy_q  <= busy_d;
      for (int u = 0; u < NUM_USERS; u++) cnt_q[u] <= cnt_d[u];
    end
  end

  assign o_Combine_process_request = req_q;
  assign o_Combine_user_index      = uidx_q;
  assign o_user_pending_ovf        = ovf_q;
  assign o_busy                    = busy_q;

endmodule

// File: tb/tb_combine_user_scheduler.sv
// Self-checking bench for combine_user_scheduler: table vectors, directed
// corner sequences and random traffic against a cycle-level reference model.
module tb_combine_user_scheduler;

  localparam int N    = 8;
  localparam int UW   = 4;
  localparam int PW   = 2;
  localparam int CMAX = (1 << PW) - 1;

  localparam int M_IDLE = 0, M_SEL = 1, M_PROG = 2, M_COMP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, comp = 1'b0;
  logic [N-1:0]  mask = '1;
  logic [N-1:0]  ind  = '0;
  logic          req;
  logic [UW-1:0] idx;
  logic [N-1:0]  ovf;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int           m_state;
  int           m_cnt [N];
  logic [N-1:0] m_ovf;
  int           m_ptr;
  int           m_user;
  logic [N-1:0] m_ind;

  combine_user_scheduler #(.NUM_USERS(N), .UIDX_W(UW), .PEND_W(PW)) dut (
    .i_core_clk                              (clk),
    .i_rx_rstn                               (rst_n),
    .i_rdm_slot_start                        (start),
    .i_slot_abort                            (abort),
    .i_user_enable_mask                      (mask),
    .io_Input_PingPong_Buffer_Write_Indicator(ind),
    .i_current_cb_combine_comp               (comp),
    .o_Combine_process_request               (req),
    .o_Combine_user_index                    (idx),
    .o_user_pending_ovf                      (ovf),
    .o_busy                                  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_state = M_IDLE;
    for (int u = 0; u < N; u++) m_cnt[u] = 0;
    m_ovf  = '0;
    m_ptr  = 0;
    m_user = 0;
    m_ind  = '0;
  endfunction

  // One clock of the scheduler as described by its rules.
  function automatic void m_step();
    logic [N-1:0] evt;
    int           old_cnt [N];
    bit           dec;
    evt   = ind ^ m_ind;
    m_ind = ind;
    if (abort) begin
      m_state = M_IDLE;
      for (int u = 0; u < N; u++) m_cnt[u] = 0;
      m_ovf = '0;
      m_ptr = 0;
      return;
    end
    for (int u = 0; u < N; u++) old_cnt[u] = m_cnt[u];
    for (int u = 0; u < N; u++) begin
      dec = (m_state == M_COMP) && (m_user == u);
      if (evt[u] && !dec) begin
        if (m_cnt[u] == CMAX) m_ovf[u] = 1'b1;
        else                  m_cnt[u]++;
      end else if (dec && !evt[u] && m_cnt[u] > 0) begin
        m_cnt[u]--;
      end
    end
    case (m_state)
      M_IDLE: if (start) m_state = M_SEL;
      M_SEL: begin
        for (int k = 0; k < N; k++) begin
          int u;
          u = (m_ptr + k) % N;
          if (old_cnt[u] > 0 && mask[u]) begin
            m_user  = u;
            m_state = M_PROG;
            break;
          end
        end
      end
      M_PROG: if (comp) m_state = M_COMP;
      default: begin
        m_ptr   = (m_user + 1) % N;
        m_state = M_SEL;
      end
    endcase
  endfunction

  task automatic tick();
    logic [UW-1:0] e_idx;
    m_step();
    @(posedge clk);
    #1;
    e_idx = (m_state == M_PROG || m_state == M_COMP) ? m_user[UW-1:0] : '1;
    check("req",  req,  (m_state == M_PROG));
    check("idx",  idx,  e_idx);
    check("busy", busy, (m_state != M_IDLE));
    check("ovf",  ovf,  m_ovf);
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_req(output int got);
    got = -1;
    for (int i = 0; i < 40; i++) begin
      if (req === 1'b1) begin
        got = int'(idx);
        break;
      end
      tick();
    end
    check("req_wait_timeout", (got >= 0), 1);
  endtask

  // Complete one grant; tog_in_comp is toggled on the indicator during COMP.
  task automatic serve(input logic [N-1:0] tog_in_comp, output int got);
    wait_req(got);
    comp = 1'b1; tick(); comp = 1'b0;
    ind = ind ^ tog_in_comp;
    tick();
  endtask

  typedef struct {
    logic         abort;
    logic         start;
    logic [N-1:0] ind;
    logic         comp;
    logic         e_req;
    logic [UW-1:0] e_idx;
    logic         e_busy;
  } vec_t;

  vec_t tbl [14];
  int   g, g1, g2, g3;

  initial begin
    tbl[0]  = '{0, 1, 8'h00, 0, 0, 4'hF, 1};
    tbl[1]  = '{0, 0, 8'h08, 0, 0, 4'hF, 1};
    tbl[2]  = '{0, 0, 8'h08, 0, 1, 4'h3, 1};
    tbl[3]  = '{0, 0, 8'h08, 0, 1, 4'h3, 1};
    tbl[4]  = '{0, 0, 8'h08, 1, 0, 4'h3, 1};
    tbl[5]  = '{0, 0, 8'h08, 0, 0, 4'hF, 1};
    tbl[6]  = '{0, 0, 8'h08, 0, 0, 4'hF, 1};
    tbl[7]  = '{0, 0, 8'h08, 1, 0, 4'hF, 1};
    tbl[8]  = '{1, 0, 8'h08, 0, 0, 4'hF, 0};
    tbl[9]  = '{0, 0, 8'h08, 0, 0, 4'hF, 0};
    tbl[10] = '{0, 0, 8'h00, 0, 0, 4'hF, 0};
    tbl[11] = '{0, 1, 8'h00, 0, 0, 4'hF, 1};
    tbl[12] = '{0, 0, 8'h00, 0, 1, 4'h3, 1};
    tbl[13] = '{1, 0, 8'h00, 1, 0, 4'hF, 0};

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",  req,  0);
    check("rst_idx",  idx,  4'hF);
    check("rst_busy", busy, 0);
    check("rst_ovf",  ovf,  8'h00);
    rst_n = 1'b1;

    // Single-user walk-through, comp outside PROGRESS, abort priority.
    for (int i = 0; i < 14; i++) begin
      abort = tbl[i].abort;
      start = tbl[i].start;
      ind   = tbl[i].ind;
      comp  = tbl[i].comp;
      tick();
      check($sformatf("tbl%0d_req", i),  req,  tbl[i].e_req);
      check($sformatf("tbl%0d_idx", i),  idx,  tbl[i].e_idx);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
    end
    abort = 0; start = 0; comp = 0;

    // Round-robin: pointer left at 5 after serving user 4; 1,4,6 pending.
    pulse_abort();
    ind = ind ^ 8'h10; tick();
    pulse_start();
    wait_req(g);
    check("rr_first", g, 4);
    ind = ind ^ 8'h52; tick();
    comp = 1'b1; tick(); comp = 1'b0;
    tick();
    serve('0, g1);
    serve('0, g2);
    serve('0, g3);
    check("rr_grant0", g1, 6);
    check("rr_grant1", g2, 1);
    check("rr_grant2", g3, 4);
    repeat (4) tick();
    check("rr_quiet", req, 0);

    // Saturation and sticky overflow.
    pulse_abort();
    for (int i = 0; i < 4; i++) begin
      ind = ind ^ 8'h04; tick();
    end
    check("sat_ovf", ovf, 8'h04);
    pulse_start();
    serve('0, g);
    check("sat_grant", g, 2);
    check("sat_ovf_sticky", ovf, 8'h04);
    serve('0, g1);
    serve('0, g2);
    check("sat_grant_b", g1, 2);
    check("sat_grant_c", g2, 2);
    repeat (5) tick();
    check("sat_drained_req", req, 0);
    check("sat_drained_busy", busy, 1);

    // Write on the user being decremented in COMP.
    pulse_abort();
    ind = ind ^ 8'h20; tick();
    pulse_start();
    serve(8'h20, g);
    check("simul_first", g, 5);
    serve('0, g1);
    check("simul_regrant", g1, 5);
    repeat (4) tick();
    check("simul_quiet", req, 0);

    // Mask holds SELECT until user 0 is enabled.
    pulse_abort();
    mask = 8'hFE;
    ind = ind ^ 8'h01; tick();
    pulse_start();
    repeat (4) tick();
    check("mask_blocked_req", req, 0);
    check("mask_blocked_busy", busy, 1);
    mask = 8'hFF;
    tick();
    check("mask_grant_req", req, 1);
    check("mask_grant_idx", idx, 4'h0);
    comp = 1'b1; tick(); comp = 1'b0; tick();

    // Abort during PROGRESS.
    pulse_abort();
    ind = ind ^ 8'h84; tick();
    pulse_start();
    wait_req(g);
    check("abort_grant", g, 2);
    pulse_abort();
    check("abort_req",  req,  0);
    check("abort_idx",  idx,  4'hF);
    check("abort_busy", busy, 0);
    comp = 1'b1; tick(); comp = 1'b0;
    check("abort_comp_ignored", busy, 0);
    pulse_start();
    repeat (6) tick();
    check("abort_cleared", req, 0);

    // Reset mid-grant, then indicator bits high right after release.
    ind = ind ^ 8'h02; tick(); tick();
    check("rst_mid_req", req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_async_req",  req,  0);
    check("rst_mid_async_idx",  idx,  4'hF);
    check("rst_mid_async_busy", busy, 0);
    @(posedge clk);
    #1;
    m_reset();
    rst_n = 1'b1;
    ind = 8'h81;
    tick();
    pulse_start();
    wait_req(g);
    check("rst_release_event", g, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      abort = ($urandom % 60) == 0;
      start = ($urandom % 4) == 0;
      comp  = ($urandom % 3) == 0;
      if (($urandom % 3) == 0) ind = ind ^ N'(1 << ($urandom % N));
      if (($urandom % 50) == 0) mask = N'($urandom) | N'($urandom);
      tick();
    end
    abort = 0; start = 0; comp = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
